// File: rtl/encap_tx_arbiter.sv
// rtl/encap_tx_arbiter.sv - round-robin arbiter sharing one ip_encapsulator between NUM_REQ requesters
// Optional ARB_STATS_EN adds per-requester packet counters and a payload stall counter.
module encap_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int META_WIDTH = 128,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ*META_WIDTH-1:0] s_meta_tdata,
  input  logic [NUM_REQ-1:0]            s_meta_tvalid,
  output logic [NUM_REQ-1:0]            s_meta_tready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_REQ-1:0]            s_axis_tvalid,
  input  logic [NUM_REQ-1:0]            s_axis_tlast,
  input  logic [NUM_REQ-1:0]            s_axis_tuser,
  output logic [NUM_REQ-1:0]            s_axis_tready,
  output logic [META_WIDTH-1:0]         m_meta_tdata,
  output logic                          m_meta_tvalid,
  input  logic                          m_meta_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic                          m_axis_tready,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         pkt_count,
  output logic [15:0]                   stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, META, PAYLOAD} state_t;

  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ-1);

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       next_grant;
  logic                   any_req;
  logic [2*NUM_REQ-1:0]   req_dbl;
  logic [NUM_REQ-1:0]     req_rot;
  logic [IDX_W:0]         pick_sum;

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner.
  always_comb begin
    req_dbl  = {s_meta_tvalid, s_meta_tvalid} >> rr_ptr;
    req_rot  = req_dbl[NUM_REQ-1:0];
    any_req  = 1'b0;
    pick_sum = '0;
    for (int j = NUM_REQ-1; j >= 0; j--) begin
      if (req_rot[j]) begin
        pick_sum = {1'b0, rr_ptr} + (IDX_W+1)'(j);
        any_req  = 1'b1;
      end
    end
    next_grant = (pick_sum >= NUM_REQ_W) ? IDX_W'(pick_sum - NUM_REQ_W) : IDX_W'(pick_sum);
  end

  always_comb begin
    s_meta_tready = '0;
    s_axis_tready = '0;
    m_meta_tdata  = '0;
    m_meta_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    busy          = rstn && (state != IDLE);
    if (rstn && state == META) begin
      m_meta_tvalid           = s_meta_tvalid[grant_id];
      s_meta_tready[grant_id] = m_meta_tready;
      if (s_meta_tvalid[grant_id])
        m_meta_tdata = s_meta_tdata[int'(grant_id)*META_WIDTH +: META_WIDTH];
    end
    if (rstn && state == PAYLOAD) begin
      m_axis_tvalid           = s_axis_tvalid[grant_id];
      s_axis_tready[grant_id] = m_axis_tready;
      if (s_axis_tvalid[grant_id]) begin
        m_axis_tdata = s_axis_tdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep = s_axis_tkeep[int'(grant_id)*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tlast = s_axis_tlast[grant_id];
        m_axis_tuser = s_axis_tuser[grant_id];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= next_grant;
            state    <= META;
          end
        end
        META: begin
          if (m_meta_tvalid && m_meta_tready) state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            rr_ptr <= (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
        pkt_count[int'(grant_id)*16 +: 16] <= pkt_count[int'(grant_id)*16 +: 16] + 16'd1;
      if (m_axis_tvalid && !m_axis_tready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_encap_tx_arbiter.sv
// tb/tb_encap_tx_arbiter.sv - scoreboard bench for encap_tx_arbiter (ARB_STATS_EN checked when defined)
module tb_encap_tx_arbiter;
  localparam int N = 4, DW = 64, KW = 8, MW = 128, IW = 2, MAXP = 512;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [N*MW-1:0] s_meta_tdata;
  logic [N-1:0]    s_meta_tvalid, s_meta_tready;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic [N-1:0]    s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
  logic [MW-1:0]   m_meta_tdata;
  logic            m_meta_tvalid, m_meta_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
  logic [IW-1:0]   grant_id;
  logic            busy;
`ifdef ARB_STATS_EN
  logic [N*16-1:0] pkt_count;
  logic [15:0]     stall_count;
`endif

  encap_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .META_WIDTH(MW), .IDX_W(IW)) dut (
    .clk(clk), .rstn(rstn),
    .s_meta_tdata(s_meta_tdata), .s_meta_tvalid(s_meta_tvalid), .s_meta_tready(s_meta_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .m_meta_tdata(m_meta_tdata), .m_meta_tvalid(m_meta_tvalid), .m_meta_tready(m_meta_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .grant_id(grant_id), .busy(busy)
`ifdef ARB_STATS_EN
    , .pkt_count(pkt_count), .stall_count(stall_count)
`endif
  );

  typedef struct packed {
    logic          is_meta;
    logic [IW-1:0] gid;
    logic [MW-1:0] meta;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          last;
    logic          user;
  } item_t;

  item_t         exp_q[$];
  item_t         mon_it;
  int            req_q [N][$];
  logic [MW-1:0] pmeta [MAXP];
  int            pnb   [MAXP];
  logic [DW-1:0] pd    [MAXP][8];
  logic [KW-1:0] pk    [MAXP][8];
  logic          pu    [MAXP][8];
  int            cnt   [N];
  int            exp_pkts [N];
  int n_cmp = 0, n_fail = 0, next_id = 0, model_ptr = 0;
  int gap_pct = 0, rdy_mode = 0, rdy_cnt = 0, stall_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Requester r: offers queued packets, meta and payload independently, with optional bubbles.
  for (genvar r = 0; r < N; r++) begin : g_req
    logic mv, av, al, au;
    logic [MW-1:0] md;
    logic [DW-1:0] ad;
    logic [KW-1:0] ak;
    assign s_meta_tvalid[r]            = mv;
    assign s_meta_tdata[r*MW +: MW]    = md;
    assign s_axis_tvalid[r]            = av;
    assign s_axis_tdata[r*DW +: DW]    = ad;
    assign s_axis_tkeep[r*KW +: KW]    = ak;
    assign s_axis_tlast[r]             = al;
    assign s_axis_tuser[r]             = au;
    initial begin
      int cur, bi;
      bit active, acc_m, acc_a;
      mv = 0; av = 0; al = 0; au = 0; md = '0; ad = '0; ak = '0;
      cur = 0; bi = 0; active = 0;
      forever begin
        @(negedge clk);
        acc_m = mv && s_meta_tready[r];
        acc_a = av && s_axis_tready[r];
        @(posedge clk);
        #1;
        if (!rstn) begin
          active = 0; mv = 0; av = 0; al = 0; au = 0; md = '0; ad = '0; ak = '0;
        end else begin
          if (active && acc_m) begin mv = 0; md = '0; end
          if (active && acc_a) begin
            av = 0; bi++;
            if (bi == pnb[cur]) active = 0;
          end
          if (!active && req_q[r].size() > 0) begin
            cur = req_q[r].pop_front(); active = 1; bi = 0; mv = 1; md = pmeta[cur];
          end
          if (active && !av && bi < pnb[cur] && int'($urandom_range(99)) >= gap_pct) begin
            av = 1; ad = pd[cur][bi]; ak = pk[cur][bi]; al = (bi == pnb[cur]-1); au = pu[cur][bi];
          end
        end
      end
    end
  end

  initial begin
    m_meta_tready = 0;
    m_axis_tready = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: begin m_meta_tready = 1; m_axis_tready = 1; end
        1: begin m_meta_tready = ($urandom_range(3) != 0); m_axis_tready = ($urandom_range(2) != 0); end
        default: begin
          m_meta_tready = (rdy_cnt >= 5);
          m_axis_tready = (rdy_cnt >= 5) && (rdy_cnt % 2 == 1);
          rdy_cnt++;
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every downstream handshake and checks grant exclusivity.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      stall_seen = 0;
    end else begin
      if (m_meta_tvalid && m_axis_tvalid) fail_now("meta_and_payload_both_valid");
      if (busy) begin
        check("nongrant_tready", 128'((s_meta_tready | s_axis_tready) & ~(N'(1) << grant_id)), 128'(0));
        check("payload_before_meta", 128'(s_axis_tready & {N{m_meta_tvalid}}), 128'(0));
      end else begin
        check("idle_outputs", 128'({s_meta_tready, s_axis_tready, m_meta_tvalid, m_axis_tvalid}), 128'(0));
      end
      if (m_meta_tvalid && m_meta_tready) begin
        if (exp_q.size() == 0) fail_now("unexpected_meta");
        else begin
          mon_it = exp_q.pop_front();
          check("meta_kind", 128'(1), 128'(mon_it.is_meta));
          check("meta_grant", 128'(grant_id), 128'(mon_it.gid));
          check("meta_data", m_meta_tdata, mon_it.meta);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else begin
          mon_it = exp_q.pop_front();
          check("beat_kind", 128'(0), 128'(mon_it.is_meta));
          check("beat_grant", 128'(grant_id), 128'(mon_it.gid));
          check("beat_data", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
                128'({mon_it.d, mon_it.k, mon_it.last, mon_it.user}));
        end
      end
      if (m_axis_tvalid && !m_axis_tready) stall_seen++;
    end
  end

  // Builds cnt[r] packets per requester and predicts the grant sequence by plain rotation.
  task automatic do_round(input int bmin, input int bmax);
    int ids [N][$];
    int left [N];
    int total, id, nb, r;
    item_t it;
    total = 0;
    for (int q = 0; q < N; q++) begin
      left[q] = cnt[q];
      total += cnt[q];
      for (int p = 0; p < cnt[q]; p++) begin
        id = next_id % MAXP;
        next_id++;
        nb = int'($urandom_range(bmax, bmin));
        pnb[id] = nb;
        pmeta[id] = {16'(nb*8), $urandom, $urandom, 16'($urandom), 16'($urandom), 8'($urandom), 8'(q)};
        for (int b = 0; b < nb; b++) begin
          pd[id][b] = {$urandom, $urandom};
          pk[id][b] = (b == nb-1) ? 8'($urandom_range(255, 1)) : 8'hFF;
          pu[id][b] = 1'($urandom_range(1));
        end
        ids[q].push_back(id);
      end
    end
    while (total > 0) begin
      r = model_ptr;
      while (left[r] == 0) r = (r + 1) % N;
      id = ids[r].pop_front();
      left[r]--; total--; exp_pkts[r]++;
      it = '0; it.is_meta = 1; it.gid = IW'(r); it.meta = pmeta[id];
      exp_q.push_back(it);
      for (int b = 0; b < pnb[id]; b++) begin
        it = '0; it.gid = IW'(r); it.d = pd[id][b]; it.k = pk[id][b];
        it.last = (b == pnb[id]-1); it.user = pu[id][b];
        exp_q.push_back(it);
      end
      req_q[r].push_back(id);
      model_ptr = (r + 1) % N;
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      fail_now({name, "_timeout"});
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    check({name, "_busy_after"}, 128'(busy), 128'(0));
  endtask

  initial begin
    int t;
    rstn = 0;
    for (int r = 0; r < N; r++) exp_pkts[r] = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_grant", 128'(grant_id), 128'(0));
    check("rst_outputs", 128'({s_meta_tready, s_axis_tready, m_meta_tvalid, m_axis_tvalid}), 128'(0));
    rstn = 1;
    @(negedge clk);

    cnt = '{2, 1, 1, 1};
    do_round(1, 1);
    wait_drain("all_four");

    cnt = '{0, 1, 0, 0};
    do_round(2, 2);
    @(negedge clk);
    check("single_idle_cycle", 128'(m_meta_tvalid), 128'(0));
    @(negedge clk);
    check("single_meta_valid", 128'(m_meta_tvalid), 128'(1));
    check("single_grant", 128'(grant_id), 128'(1));
    check("single_busy", 128'(busy), 128'(1));
    wait_drain("single");

    cnt = '{1, 0, 0, 1};
    do_round(1, 3);
    wait_drain("wrap_order");

    rdy_cnt = 0;
    rdy_mode = 2;
    cnt = '{1, 0, 1, 0};
    do_round(4, 4);
    wait_drain("stall");

    rdy_mode = 1;
    gap_pct = 30;
    for (int k = 0; k < 25; k++) begin
      for (int r = 0; r < N; r++) cnt[r] = int'($urandom_range(2));
      if (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) cnt[k % N] = 1;
      do_round(1, 6);
      wait_drain("random");
    end

    rdy_mode = 0;
    gap_pct = 0;
    cnt = '{0, 0, 1, 0};
    do_round(2, 2);
    wait_drain("pre_reset");
    do_round(4, 4);
    t = 0;
    while (exp_q.size() > 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 3) fail_now("mid_packet_timeout");
    rstn = 0;
    @(negedge clk);
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_outputs", 128'({s_meta_tready, s_axis_tready, m_meta_tvalid, m_axis_tvalid}), 128'(0));
    model_ptr = 0;
    for (int r = 0; r < N; r++) exp_pkts[r] = 0;
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    cnt = '{0, 1, 1, 1};
    do_round(1, 3);
    wait_drain("post_reset");

`ifdef ARB_STATS_EN
    for (int r = 0; r < N; r++)
      check($sformatf("pkt_count_%0d", r), 128'(pkt_count[r*16 +: 16]), 128'(exp_pkts[r]));
    check("stall_count", 128'(stall_count), 128'(stall_seen));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
